// File: rtl/penalty_round_ctl.sv
// Game-flow sequencer for the penalty simulator: START -> AIM -> FLIGHT -> RESULT -> ... -> END.
// All state changes commit on the registered vblank-rise tick so each drawn frame is consistent.
module penalty_round_ctl #(
   parameter int ROUNDS        = 5,
   parameter int FLIGHT_FRAMES = 30,
   parameter int RESULT_FRAMES = 90
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vblnk,
   input  logic       start_btn,
   input  logic       shot_valid,
   output logic       shot_ready,
   input  logic [1:0] shot_dir,
   input  logic [1:0] keeper_dir,
   output logic       frame_tick,
   output logic [2:0] game_state,
   output logic [3:0] round_counter,
   output logic [2:0] score,
   output logic       is_scored,
   output logic [6:0] anim_frame
);

   typedef enum logic [2:0] {
      ST_START  = 3'd0,
      ST_AIM    = 3'd1,
      ST_FLIGHT = 3'd2,
      ST_RESULT = 3'd3,
      ST_END    = 3'd4
   } state_t;

   localparam logic [6:0] FLIGHT_LAST = 7'(FLIGHT_FRAMES - 1);
   localparam logic [6:0] RESULT_LAST = 7'(RESULT_FRAMES - 1);
   localparam logic [3:0] ROUNDS_W    = 4'(ROUNDS);

   state_t state;
   logic   vblnk_d;
   logic   start_btn_d;
   logic   start_pend;
   logic   shot_pend;
   logic   start_rise;
   logic   handshake;
   logic   goal;

   assign game_state = state;
   assign start_rise = start_btn & ~start_btn_d;
   assign shot_ready = (state == ST_AIM) && !shot_pend;
   assign handshake  = shot_valid & shot_ready;
   assign goal       = (shot_dir != keeper_dir);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_START;
         vblnk_d       <= 1'b0;
         start_btn_d   <= 1'b0;
         frame_tick    <= 1'b0;
         start_pend    <= 1'b0;
         shot_pend     <= 1'b0;
         round_counter <= '0;
         score         <= '0;
         is_scored     <= 1'b0;
         anim_frame    <= '0;
      end else begin
         vblnk_d     <= vblnk;
         start_btn_d <= start_btn;
         frame_tick  <= vblnk & ~vblnk_d;

         // NOTE: later non-blocking assignments in this block win, so the tick
         // handling below overrides these request-capture defaults.
         if (start_rise && (state == ST_START || state == ST_END))
            start_pend <= 1'b1;

         if (handshake) begin
            shot_pend <= 1'b1;
            is_scored <= goal;
            if (goal && score != 3'd7)
               score <= score + 3'd1;
         end

         case (state)
            ST_START: if (frame_tick && start_pend) begin
               state         <= ST_AIM;
               start_pend    <= 1'b0;
               round_counter <= '0;
               score         <= '0;
               is_scored     <= 1'b0;
               anim_frame    <= '0;
            end
            ST_AIM: if (frame_tick && shot_pend) begin
               state      <= ST_FLIGHT;
               anim_frame <= '0;
            end
            ST_FLIGHT: if (frame_tick) begin
               if (anim_frame == FLIGHT_LAST) begin
                  state      <= ST_RESULT;
                  anim_frame <= '0;
               end else if (anim_frame != 7'd127) begin
                  anim_frame <= anim_frame + 7'd1;
               end
            end
            ST_RESULT: if (frame_tick) begin
               if (anim_frame == RESULT_LAST) begin
                  round_counter <= round_counter + 4'd1;
                  shot_pend     <= 1'b0;
                  anim_frame    <= '0;
                  state         <= (round_counter + 4'd1 == ROUNDS_W) ? ST_END : ST_AIM;
               end else if (anim_frame != 7'd127) begin
                  anim_frame <= anim_frame + 7'd1;
               end
            end
            ST_END: if (frame_tick && start_pend) begin
               state      <= ST_START;
               start_pend <= 1'b0;
            end
            default: state <= ST_START;
         endcase
      end
   end

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Directed bench for penalty_round_ctl: reset, start, goal, save with tick collision,
// full game to END and restart, backpressure, and reset in the middle of a flight.
module tb_penalty_round_ctl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vblnk;
   logic       start_btn;
   logic       shot_valid;
   logic       shot_ready;
   logic [1:0] shot_dir;
   logic [1:0] keeper_dir;
   logic       frame_tick;
   logic [2:0] game_state;
   logic [3:0] round_counter;
   logic [2:0] score;
   logic       is_scored;
   logic [6:0] anim_frame;

   int n_checks = 0;
   int n_fail   = 0;

   penalty_round_ctl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .vblnk        (vblnk),
      .start_btn    (start_btn),
      .shot_valid   (shot_valid),
      .shot_ready   (shot_ready),
      .shot_dir     (shot_dir),
      .keeper_dir   (keeper_dir),
      .frame_tick   (frame_tick),
      .game_state   (game_state),
      .round_counter(round_counter),
      .score        (score),
      .is_scored    (is_scored),
      .anim_frame   (anim_frame)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One video frame: vblank high for two cycles (tick then commit), low for two.
   task automatic frame();
      vblnk = 1'b1;
      step();
      step();
      vblnk = 1'b0;
      step();
      step();
   endtask

   task automatic shoot(input logic [1:0] sd, input logic [1:0] kd);
      shot_valid = 1'b1;
      shot_dir   = sd;
      keeper_dir = kd;
      step();
      shot_valid = 1'b0;
   endtask

   task automatic play_round(input logic [1:0] sd, input logic [1:0] kd);
      shoot(sd, kd);
      step();
      repeat (121) frame();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vblnk = 1'b0; start_btn = 1'b0; shot_valid = 1'b0;
      shot_dir = 2'd0; keeper_dir = 2'd0;
      repeat (3) step();
      n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", game_state); end
      n_checks++; if (round_counter !== 4'd0) begin n_fail++; $display("FAIL reset_rounds: got %0d want 0", round_counter); end
      n_checks++; if (score !== 3'd0 || is_scored !== 1'b0) begin n_fail++; $display("FAIL reset_score: got score=%0d is_scored=%0d want 0/0", score, is_scored); end
      n_checks++; if (anim_frame !== 7'd0 || shot_ready !== 1'b0 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_misc: got anim=%0d ready=%0d tick=%0d want 0/0/0", anim_frame, shot_ready, frame_tick); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_start();
      start_btn = 1'b1;
      step();
      n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL start_waits_tick: got %0d want 0", game_state); end
      vblnk = 1'b1;
      step();
      n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL tick_high: got %0d want 1", frame_tick); end
      n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL start_before_commit: got %0d want 0", game_state); end
      step();
      n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_one_cycle: got %0d want 0", frame_tick); end
      n_checks++; if (game_state !== 3'd1 || shot_ready !== 1'b1) begin n_fail++; $display("FAIL start_to_aim: got state=%0d ready=%0d want 1/1", game_state, shot_ready); end
      vblnk = 1'b0;
      step(); step();
      frame();
      n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL held_button_aim: got %0d want 1", game_state); end
      start_btn = 1'b0;
      step();
   endtask

   task automatic test_goal();
      shoot(2'd2, 2'd1);
      n_checks++; if (shot_ready !== 1'b0) begin n_fail++; $display("FAIL goal_ready_drop: got %0d want 0", shot_ready); end
      n_checks++; if (is_scored !== 1'b1 || score !== 3'd1) begin n_fail++; $display("FAIL goal_score: got is_scored=%0d score=%0d want 1/1", is_scored, score); end
      n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL goal_waits_tick: got %0d want 1", game_state); end
      frame();
      n_checks++; if (game_state !== 3'd2 || anim_frame !== 7'd0) begin n_fail++; $display("FAIL goal_flight: got state=%0d anim=%0d want 2/0", game_state, anim_frame); end
      // Backpressure: a would-be goal held on shot_valid through FLIGHT and RESULT.
      shot_valid = 1'b1; shot_dir = 2'd0; keeper_dir = 2'd1;
      repeat (29) frame();
      n_checks++; if (game_state !== 3'd2 || anim_frame !== 7'd29) begin n_fail++; $display("FAIL flight_end: got state=%0d anim=%0d want 2/29", game_state, anim_frame); end
      n_checks++; if (shot_ready !== 1'b0 || score !== 3'd1) begin n_fail++; $display("FAIL flight_backpressure: got ready=%0d score=%0d want 0/1", shot_ready, score); end
      frame();
      n_checks++; if (game_state !== 3'd3 || anim_frame !== 7'd0) begin n_fail++; $display("FAIL goal_result: got state=%0d anim=%0d want 3/0", game_state, anim_frame); end
      repeat (89) frame();
      n_checks++; if (game_state !== 3'd3 || anim_frame !== 7'd89) begin n_fail++; $display("FAIL result_end: got state=%0d anim=%0d want 3/89", game_state, anim_frame); end
      n_checks++; if (shot_ready !== 1'b0 || score !== 3'd1) begin n_fail++; $display("FAIL result_backpressure: got ready=%0d score=%0d want 0/1", shot_ready, score); end
      shot_valid = 1'b0;
      frame();
      n_checks++; if (game_state !== 3'd1 || round_counter !== 4'd1) begin n_fail++; $display("FAIL goal_back_to_aim: got state=%0d rounds=%0d want 1/1", game_state, round_counter); end
      n_checks++; if (anim_frame !== 7'd0 || shot_ready !== 1'b1 || score !== 3'd1) begin n_fail++; $display("FAIL goal_aim_outputs: got anim=%0d ready=%0d score=%0d want 0/1/1", anim_frame, shot_ready, score); end
   endtask

   task automatic test_save_collision();
      vblnk = 1'b1;
      step();
      shot_valid = 1'b1; shot_dir = 2'd3; keeper_dir = 2'd3;
      step();
      shot_valid = 1'b0;
      vblnk = 1'b0;
      n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL collision_no_transition: got %0d want 1", game_state); end
      n_checks++; if (is_scored !== 1'b0 || score !== 3'd1 || shot_ready !== 1'b0) begin n_fail++; $display("FAIL save_outputs: got is_scored=%0d score=%0d ready=%0d want 0/1/0", is_scored, score, shot_ready); end
      step(); step();
      frame();
      n_checks++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL collision_next_tick: got %0d want 2", game_state); end
      repeat (120) frame();
      n_checks++; if (game_state !== 3'd1 || round_counter !== 4'd2 || score !== 3'd1) begin n_fail++; $display("FAIL save_round_done: got state=%0d rounds=%0d score=%0d want 1/2/1", game_state, round_counter, score); end
   endtask

   task automatic test_game_end();
      play_round(2'd0, 2'd1);
      play_round(2'd1, 2'd1);
      n_checks++; if (game_state !== 3'd1 || round_counter !== 4'd4 || score !== 3'd2) begin n_fail++; $display("FAIL round4: got state=%0d rounds=%0d score=%0d want 1/4/2", game_state, round_counter, score); end
      play_round(2'd3, 2'd2);
      n_checks++; if (game_state !== 3'd4 || round_counter !== 4'd5 || score !== 3'd3) begin n_fail++; $display("FAIL game_end: got state=%0d rounds=%0d score=%0d want 4/5/3", game_state, round_counter, score); end
      shot_valid = 1'b1; shot_dir = 2'd2; keeper_dir = 2'd0;
      step(); step();
      n_checks++; if (shot_ready !== 1'b0 || score !== 3'd3 || is_scored !== 1'b1) begin n_fail++; $display("FAIL end_backpressure: got ready=%0d score=%0d is_scored=%0d want 0/3/1", shot_ready, score, is_scored); end
      frame();
      n_checks++; if (game_state !== 3'd4) begin n_fail++; $display("FAIL end_holds: got %0d want 4", game_state); end
      shot_valid = 1'b0;
      start_btn = 1'b1;
      step();
      frame();
      n_checks++; if (game_state !== 3'd0 || round_counter !== 4'd5 || score !== 3'd3) begin n_fail++; $display("FAIL end_to_start: got state=%0d rounds=%0d score=%0d want 0/5/3", game_state, round_counter, score); end
      frame();
      n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL held_no_restart: got %0d want 0", game_state); end
      start_btn = 1'b0;
      step();
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      frame();
      n_checks++; if (game_state !== 3'd1 || score !== 3'd0 || round_counter !== 4'd0 || is_scored !== 1'b0) begin n_fail++; $display("FAIL restart_aim: got state=%0d score=%0d rounds=%0d is_scored=%0d want 1/0/0/0", game_state, score, round_counter, is_scored); end
   endtask

   task automatic test_reset_midgame();
      shoot(2'd2, 2'd0);
      step();
      repeat (6) frame();
      n_checks++; if (game_state !== 3'd2 || anim_frame !== 7'd5) begin n_fail++; $display("FAIL mid_flight_setup: got state=%0d anim=%0d want 2/5", game_state, anim_frame); end
      vblnk = 1'b1;
      rst_n = 1'b0;
      step();
      n_checks++; if (game_state !== 3'd0 || anim_frame !== 7'd0 || score !== 3'd0 || is_scored !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got state=%0d anim=%0d score=%0d is_scored=%0d want 0/0/0/0", game_state, anim_frame, score, is_scored); end
      n_checks++; if (round_counter !== 4'd0 || shot_ready !== 1'b0 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL mid_reset_misc: got rounds=%0d ready=%0d tick=%0d want 0/0/0", round_counter, shot_ready, frame_tick); end
      step(); step();
      vblnk = 1'b0;
      rst_n = 1'b1;
      step();
      frame();
      n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL reset_stays_start: got %0d want 0", game_state); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_goal();
      test_save_collision();
      test_game_end();
      test_reset_midgame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
